// File: rtl/decoder_pkg.sv
// decoder_pkg: shared mode and FSM state types for decoder_pipe.
// Mode 3 is reserved and decodes like DEC_MODE_DECODE.
package decoder_pkg;

  typedef enum logic [1:0] {
    DEC_MODE_DECODE = 2'd0,
    DEC_MODE_SWEEP  = 2'd1,
    DEC_MODE_THERMO = 2'd2
  } dec_mode_e;

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } dec_state_e;

endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: combinational index decoder, AW bits to 2**AW lines.
// thermo=1 sets every line at or below idx instead of just one.
module onehot_dec #(
  parameter int AW = 5,
  localparam int NW = 2**AW
) (
  input  logic [AW-1:0] idx,
  input  logic          thermo,
  output logic [NW-1:0] z
);

  always_comb begin
    z = '0;
    for (int i = 0; i < NW; i++) begin
      z[i] = thermo ? (AW'(i) <= idx)
                    : (AW'(i) == idx);
    end
  end

endmodule

// File: rtl/decoder_pipe.sv
// decoder_pipe: registered one-hot decoder with sweep mode, valid/ready on both sides.
// Define DECODER_PIPE_THERMO_EN to enable the thermometer mode (mode 2).
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter int AW = 5,
  localparam int NW = 2**AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] A,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] Z,
  output logic [AW-1:0] Z_idx,
  output logic          sweep_done
);

  dec_state_e    state, state_d;
  logic [AW-1:0] nxt, nxt_d;
  logic [AW-1:0] sel_idx, idx_d;
  logic [NW-1:0] sel_z, z_d;
  logic          ov_d, done_d;
  logic          accept, hs, load_sw;
  logic          is_sweep, thermo, last;

  assign in_ready = (state == ST_IDLE)
                  & (!out_valid | out_ready)
                  & rst_n;
  assign accept   = in_valid & in_ready;
  assign hs       = out_valid & out_ready;
  assign load_sw  = (state == ST_SWEEP) & hs;
  assign is_sweep = (mode == DEC_MODE_SWEEP);

`ifdef DECODER_PIPE_THERMO_EN
  assign thermo = (state == ST_IDLE)
                & (mode == DEC_MODE_THERMO);
`else
  assign thermo = 1'b0;
`endif

  // While sweeping, the decoder runs on the captured counter, not A
  assign sel_idx = (state == ST_SWEEP) ? nxt : A;
  assign last    = &sel_idx;

  onehot_dec #(.AW(AW)) u_dec (
    .idx    (sel_idx),
    .thermo (thermo),
    .z      (sel_z)
  );

  always_comb begin
    state_d = state;
    nxt_d   = nxt;
    ov_d    = out_valid;
    z_d     = Z;
    idx_d   = Z_idx;
    done_d  = sweep_done;
    if (hs) begin
      ov_d   = 1'b0;
      z_d    = '0;
      idx_d  = '0;
      done_d = 1'b0;
    end
    unique case (1'b1)
      accept: begin
        ov_d   = 1'b1;
        z_d    = sel_z;
        idx_d  = A;
        done_d = is_sweep & last;
        if (is_sweep) begin
          nxt_d = A + AW'(1);
          if (!last) state_d = ST_SWEEP;
        end
      end
      load_sw: begin
        ov_d   = 1'b1;
        z_d    = sel_z;
        idx_d  = nxt;
        done_d = last;
        nxt_d  = nxt + AW'(1);
        if (last) state_d = ST_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      nxt        <= '0;
      out_valid  <= 1'b0;
      Z          <= '0;
      Z_idx      <= '0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_d;
      nxt        <= nxt_d;
      out_valid  <= ov_d;
      Z          <= z_d;
      Z_idx      <= idx_d;
      sweep_done <= done_d;
    end
  end

endmodule

// File: tb/tb_decoder_pipe.sv
// tb_decoder_pipe: directed table, corner sequences and a randomized
// queue-based beat model for decoder_pipe.
module tb_decoder_pipe;

  localparam int AW = 5;
  localparam int NW = 2**AW;

`ifdef DECODER_PIPE_THERMO_EN
  localparam bit THERMO = 1'b1;
`else
  localparam bit THERMO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    mode;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] A;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] Z;
  logic [AW-1:0] Z_idx;
  logic          sweep_done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [NW-1:0] z;
    logic [AW-1:0] idx;
    logic          done;
  } beat_t;

  typedef struct {
    int            m;
    int            a;
    logic [NW-1:0] z;
    int            idx;
    logic          done;
  } vec_t;

  beat_t q[$];
  vec_t  v[7];

  decoder_pipe #(.AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Z          (Z),
    .Z_idx      (Z_idx),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Expected line pattern from the mode rules, using plain arithmetic
  function automatic logic [NW-1:0] code(input int m, input int a);
    logic [NW-1:0] r;
    logic [NW-1:0] one;
    one = 1;
    if (m == 2 && THERMO) r = (one << (a + 1)) - one;
    else                  r = one << a;
    return r;
  endfunction

  task automatic push_req(input int m, input int a);
    if (m == 1) begin
      for (int i = a; i < NW; i++)
        q.push_back('{code(0, i), AW'(i), (i == NW - 1)});
    end else begin
      q.push_back('{code(m, a), AW'(a), 1'b0});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rdy[5];
    int eid[5];
    int c;
    bit acc, hs, exp_rdy;

    v[0] = '{0,  2, 32'h0000_0004,  2, 1'b0};
    v[1] = '{0, 31, 32'h8000_0000, 31, 1'b0};
    v[2] = '{0,  0, 32'h0000_0001,  0, 1'b0};
    v[3] = '{3,  5, 32'h0000_0020,  5, 1'b0};
    v[4] = '{2,  3, THERMO ? 32'h0000_000F : 32'h0000_0008, 3, 1'b0};
    v[5] = '{1, 31, 32'h8000_0000, 31, 1'b1};
    v[6] = '{2, 31, THERMO ? 32'hFFFF_FFFF : 32'h8000_0000, 31, 1'b0};

    rst_n = 1'b0; in_valid = 1'b1; mode = 2'd0;
    A = 5'd3; out_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_z", 64'(Z), 64'd0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      mode = 2'(v[i].m);
      A    = AW'(v[i].a);
      in_valid = 1'b1;
      #1;
      chk("tbl_in_ready", 64'(in_ready), 64'd1);
      tick();
      chk("tbl_out_valid", 64'(out_valid), 64'd1);
      chk("tbl_z", 64'(Z), 64'(v[i].z));
      chk("tbl_idx", 64'(Z_idx), 64'(v[i].idx));
      chk("tbl_done", 64'(sweep_done), 64'(v[i].done));
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_z", 64'(Z), 64'd0);

    // Sweep from 28; a DECODE of 9 waits on the final beat
    in_valid = 1'b1; mode = 2'd1; A = 5'd28;
    #1;
    chk("sw_in_ready", 64'(in_ready), 64'd1);
    tick();
    mode = 2'd0; A = 5'd9;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("sw_valid", 64'(out_valid), 64'd1);
      chk("sw_idx", 64'(Z_idx), 64'(28 + k));
      chk("sw_z", 64'(Z), 64'(code(0, 28 + k)));
      chk("sw_done", 64'(sweep_done), 64'(k == 3));
      chk("sw_ready", 64'(in_ready), 64'(k == 3));
      tick();
    end
    chk("sw_next_idx", 64'(Z_idx), 64'd9);
    chk("sw_next_z", 64'(Z), 64'h200);
    chk("sw_next_done", 64'(sweep_done), 64'd0);
    in_valid = 1'b0;
    tick();
    chk("sw_idle", 64'(out_valid), 64'd0);

    // Backpressure during a sweep from 0
    in_valid = 1'b1; mode = 2'd1; A = 5'd0;
    tick();
    in_valid = 1'b0;
    rdy = '{1, 0, 0, 1, 1};
    eid = '{0, 1, 1, 1, 2};
    for (int j = 0; j < 5; j++) begin
      out_ready = rdy[j][0];
      #1;
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_idx", 64'(Z_idx), 64'(eid[j]));
      tick();
    end
    out_ready = 1'b1;
    c = 0;
    while (Z_idx != 5'd5 && c < 40) begin
      tick();
      c++;
    end
    chk("mid_reach5", 64'(Z_idx), 64'd5);
    rst_n = 1'b0;
    tick();
    chk("mid_valid", 64'(out_valid), 64'd0);
    chk("mid_z", 64'(Z), 64'd0);
    chk("mid_done", 64'(sweep_done), 64'd0);
    rst_n = 1'b1; in_valid = 1'b1; mode = 2'd0; A = 5'd7;
    #1;
    chk("mid_ready", 64'(in_ready), 64'd1);
    tick();
    chk("mid_z7", 64'(Z), 64'h80);
    chk("mid_idx7", 64'(Z_idx), 64'd7);
    in_valid = 1'b0;
    tick();
    chk("mid_abandon", 64'(out_valid), 64'd0);

    // Randomized traffic against the beat-queue model
    q.delete();
    for (int n = 0; n < 3000; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      mode      = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) A = AW'($urandom_range(0, NW - 1));
      else                           A = AW'($urandom_range(NW - 6, NW - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
      chk("rnd_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("rnd_ready", 64'(in_ready), 64'(exp_rdy));
      if (q.size() != 0) begin
        chk("rnd_z", 64'(Z), 64'(q[0].z));
        chk("rnd_idx", 64'(Z_idx), 64'(q[0].idx));
        chk("rnd_done", 64'(sweep_done), 64'(q[0].done));
      end else begin
        chk("rnd_zero", 64'(Z), 64'd0);
      end
      hs  = out_valid & out_ready;
      acc = in_valid & in_ready;
      if (hs && q.size() != 0) void'(q.pop_front());
      if (acc) push_req(int'(mode), int'(A));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    c = 0;
    while (q.size() != 0 && c < 100) begin
      #1;
      chk("end_z", 64'(Z), 64'(q[0].z));
      chk("end_idx", 64'(Z_idx), 64'(q[0].idx));
      if (out_valid) void'(q.pop_front());
      tick();
      c++;
    end
    chk("end_queue", 64'(q.size()), 64'd0);
    chk("end_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
